// File: rtl/fft_power_pipe_pkg.sv
// Shared widths, defaults and helpers for the FFT bin power pipeline.
package fft_power_pipe_pkg;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_FFT_LEN   = 256;
  localparam int DEF_ONE_SIDED = 1;
  localparam int DEF_SHIFT     = 0;
  localparam int PWR_MUL       = 2;
  localparam int DEF_PWR_W     = PWR_MUL * DEF_DATA_W;

  function automatic int bin_w(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return w;
  endfunction

  function automatic int pwr_w(input int dw);
    return PWR_MUL * dw;
  endfunction

endpackage

// File: rtl/fft_power_sq.sv
// Registered signed squarer; result is always non-negative.
module fft_power_sq #(
  parameter int DATA_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic signed [DATA_W-1:0] a_i,
  output logic [2*DATA_W-1:0]     sq_o
);

  logic signed [2*DATA_W-1:0] ax;
  logic signed [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0]        sq_q;

  assign ax   = (2*DATA_W)'(a_i);
  assign prod = ax * ax;
  assign sq_o = sq_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sq_q <= '0;
    end else if (en_i) begin
      sq_q <= prod;
    end
  end

endmodule

// File: rtl/fft_power_pipe.sv
// Three-stage |X|^2 pipeline with bin tagging, one-sided drop and framing check.
module fft_power_pipe
  import fft_power_pipe_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int FFT_LEN   = DEF_FFT_LEN,
  parameter int ONE_SIDED = DEF_ONE_SIDED,
  parameter int SHIFT     = DEF_SHIFT,
  parameter int OUT_W     = 2 * DATA_W
) (
  input  logic                        hclk,
  input  logic                        rst_n,
  input  logic [2*DATA_W-1:0]         data_in,
  input  logic                        valid_in,
  input  logic                        last_in,
  output logic                        ready_out,
  output logic [OUT_W-1:0]            data_out,
  output logic [bin_w(FFT_LEN)-1:0]   bin_out,
  output logic                        valid_out,
  output logic                        last,
  input  logic                        ready_in,
  output logic                        frame_err
);

  localparam int BW = bin_w(FFT_LEN);
  localparam int PW = pwr_w(DATA_W);
  localparam logic [BW-1:0] LAST_BIN = BW'(FFT_LEN - 1);
  localparam logic [BW-1:0] HALF_BIN = BW'(FFT_LEN / 2);

  logic en, acc, at_end, keep, tail;
  logic [BW-1:0] cnt_q, cnt_d;
  logic err_q;

  logic                     s1_v_q, s1_last_q;
  logic [BW-1:0]            s1_bin_q;
  logic signed [DATA_W-1:0] s1_re_q, s1_im_q;

  logic          s2_v_q, s2_last_q;
  logic [BW-1:0] s2_bin_q;
  logic [PW-1:0] sq_re, sq_im, sum, shifted;
  logic [OUT_W-1:0] pwr_d;

  logic             vo_q, last_q;
  logic [OUT_W-1:0] data_q;
  logic [BW-1:0]    bin_q;

  assign en        = ~vo_q | ready_in;
  assign ready_out = en;
  assign acc       = valid_in & en;

  always_comb begin
    at_end = (cnt_q == LAST_BIN);
    keep   = 1'b1;
    tail   = at_end;
    if (ONE_SIDED != 0) begin
      keep = (cnt_q <= HALF_BIN);
      tail = (cnt_q == HALF_BIN);
    end
    cnt_d = cnt_q;
    if (acc) cnt_d = (last_in | at_end) ? '0 : cnt_q + BW'(1);
  end

  // S1: capture beat, tag bin, decide forward/drop
  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      err_q     <= 1'b0;
      s1_v_q    <= 1'b0;
      s1_last_q <= 1'b0;
      s1_bin_q  <= '0;
      s1_re_q   <= '0;
      s1_im_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= acc & (last_in ^ at_end);
      if (en) begin
        s1_v_q    <= acc & keep;
        s1_last_q <= keep & (tail | last_in);
        s1_bin_q  <= cnt_q;
        s1_re_q   <= data_in[DATA_W-1:0];
        s1_im_q   <= data_in[2*DATA_W-1:DATA_W];
      end
    end
  end

  fft_power_sq #(.DATA_W(DATA_W)) u_sq_re (
    .clk_i (hclk),
    .rst_ni(rst_n),
    .en_i  (en),
    .a_i   (s1_re_q),
    .sq_o  (sq_re)
  );

  fft_power_sq #(.DATA_W(DATA_W)) u_sq_im (
    .clk_i (hclk),
    .rst_ni(rst_n),
    .en_i  (en),
    .a_i   (s1_im_q),
    .sq_o  (sq_im)
  );

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_last_q <= 1'b0;
      s2_bin_q  <= '0;
    end else if (en) begin
      s2_v_q    <= s1_v_q;
      s2_last_q <= s1_last_q;
      s2_bin_q  <= s1_bin_q;
    end
  end

  // Sum cannot overflow: peak is 2^(PW-1) at both inputs = -2^(DATA_W-1)
  assign sum     = sq_re + sq_im;
  assign shifted = sum >> SHIFT;

  generate
    if (OUT_W < PW) begin : g_sat
      assign pwr_d = (|shifted[PW-1:OUT_W]) ? '1 : shifted[OUT_W-1:0];
    end else begin : g_ext
      assign pwr_d = OUT_W'(shifted);
    end
  endgenerate

  always_ff @(posedge hclk or negedge rst_n) begin
    if (!rst_n) begin
      vo_q   <= 1'b0;
      last_q <= 1'b0;
      data_q <= '0;
      bin_q  <= '0;
    end else if (en) begin
      vo_q   <= s2_v_q;
      last_q <= s2_v_q & s2_last_q;
      if (s2_v_q) begin
        data_q <= pwr_d;
        bin_q  <= s2_bin_q;
      end
    end
  end

  assign valid_out = vo_q;
  assign last      = last_q;
  assign data_out  = data_q;
  assign bin_out   = bin_q;
  assign frame_err = err_q;

endmodule
